// File: rtl/tlv2548_scan_ctrl.sv
// tlv2548_scan_ctrl
//   Sweep sequencer for the TLV2548 8-channel 12-bit ADC, sitting in front of
//   a 16-bit SPI frame engine. A sweep is one CFR write, one conversion frame
//   per enabled channel (ascending), then one flush frame. The ADC returns
//   each conversion one frame late, so every frame's rx word is tagged with
//   the channel of the previous conversion frame.
//
//   Optional feature macro: TLV2548_SCAN_TIMEOUT_EN
//     defined   : WAIT_DONE is bounded by TIMEOUT_CYCLES; on expiry err pulses
//                 and the sweep is abandoned without sweep_done.
//     undefined : no watchdog, err is tied low.
//
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   start          1-clk sweep request (ignored while busy)
//   cfg_word[11:0] CFR contents, latched at start
//   ch_mask[7:0]   channel enable bitmap, latched at start
//   busy           sweep in progress
//   sample_vld     1-clk strobe for sample_ch / sample_data
//   sample_ch[2:0], sample_data[11:0]  tagged conversion result
//   sweep_done     1-clk strobe, coincides with the last sample
//   spi_trig       1-clk frame start to the SPI core
//   spi_tx_data    outgoing frame, held from spi_trig through spi_done
//   spi_rdy        SPI core idle
//   spi_done       SPI core end-of-frame strobe
//   spi_rx_data    received frame, valid with spi_done
//   err            1-clk watchdog strobe
module tlv2548_scan_ctrl #(
  parameter int GAP_CYCLES     = 200,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] cfg_word,
  input  logic [7:0]  ch_mask,
  output logic        busy,
  output logic        sample_vld,
  output logic [2:0]  sample_ch,
  output logic [11:0] sample_data,
  output logic        sweep_done,
  output logic        spi_trig,
  output logic [15:0] spi_tx_data,
  input  logic        spi_rdy,
  input  logic        spi_done,
  input  logic [15:0] spi_rx_data,
  output logic        err
);

  localparam int GW = $clog2(GAP_CYCLES + 1);

  if (GAP_CYCLES < 1) begin : g_gap_chk
    $error("GAP_CYCLES must be at least 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_tmo_chk
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT_DONE = 2'd2, GAP = 2'd3} state_t;
  typedef enum logic [1:0] {FR_CFR = 2'd0, FR_CONV = 2'd1, FR_FLUSH = 2'd2} frame_t;

  state_t        state_q, state_d;
  frame_t        kind_q, kind_d;
  logic [7:0]    rem_q, rem_d;        // enabled channels not yet issued
  logic [GW-1:0] gap_q, gap_d;
  logic          prev_vld_q, prev_vld_d;
  logic [2:0]    prev_ch_q, prev_ch_d;

  logic          busy_d, sample_vld_d, sweep_done_d, spi_trig_d, err_d;
  logic [2:0]    sample_ch_d;
  logic [11:0]   sample_data_d;
  logic [15:0]   spi_tx_data_d;

  logic          accept, last_frame, gap_end, timeout;
  logic [3:0]    unused_rx_lsbs;

  assign unused_rx_lsbs = spi_rx_data[3:0];

  function automatic logic [2:0] lowest_ch(input logic [7:0] m);
    logic [2:0] c;
    c = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) c = 3'(i);
    end
    return c;
  endfunction

`ifdef TLV2548_SCAN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_q, to_d;
  // to_q is 0 in the spi_trig cycle, so expiry lands TIMEOUT_CYCLES clks after it
  assign timeout = (state_q == WAIT_DONE) && !spi_done && (to_q == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // busy is still 1 in the sweep_done/err cycle, which blocks a start there
  assign accept     = (state_q == IDLE) && start && !busy;
  // a CFR frame ends the sweep only when no channel is enabled
  assign last_frame = (kind_q == FR_FLUSH) || ((kind_q == FR_CFR) && (rem_q == 8'h00));
  assign gap_end    = (gap_q == GW'(1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (accept) state_d = ISSUE;
      ISSUE:     if (spi_rdy) state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (spi_done)     state_d = last_frame ? IDLE : GAP;
        else if (timeout) state_d = IDLE;
      end
      GAP:       if (gap_end) state_d = ISSUE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_d        = busy & ~(sweep_done | err);
    sample_vld_d  = 1'b0;
    sample_ch_d   = sample_ch;
    sample_data_d = sample_data;
    sweep_done_d  = 1'b0;
    spi_trig_d    = 1'b0;
    err_d         = 1'b0;
    spi_tx_data_d = spi_tx_data;
    kind_d        = kind_q;
    rem_d         = rem_q;
    gap_d         = gap_q;
    prev_vld_d    = prev_vld_q;
    prev_ch_d     = prev_ch_q;
`ifdef TLV2548_SCAN_TIMEOUT_EN
    to_d          = to_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          busy_d        = 1'b1;
          rem_d         = ch_mask;
          kind_d        = FR_CFR;
          spi_tx_data_d = {4'hA, cfg_word};
          prev_vld_d    = 1'b0;
        end
      end
      ISSUE: begin
        if (spi_rdy) begin
          spi_trig_d = 1'b1;
`ifdef TLV2548_SCAN_TIMEOUT_EN
          to_d       = '0;
`endif
        end
      end
      WAIT_DONE: begin
        if (spi_done) begin
          // rx carries the result of the previous conversion frame, if any
          if ((kind_q != FR_CFR) && prev_vld_q) begin
            sample_vld_d  = 1'b1;
            sample_ch_d   = prev_ch_q;
            sample_data_d = spi_rx_data[15:4];
          end
          if (kind_q == FR_CONV) begin
            prev_ch_d  = spi_tx_data[14:12];
            prev_vld_d = 1'b1;
          end
          if (last_frame) sweep_done_d = 1'b1;
          else            gap_d        = GW'(GAP_CYCLES);
        end
`ifdef TLV2548_SCAN_TIMEOUT_EN
        else if (timeout) begin
          err_d = 1'b1;
        end else begin
          to_d = to_q + TW'(1);
        end
`endif
      end
      GAP: begin
        gap_d = gap_q - GW'(1);
        if (gap_end) begin
          if (rem_q != 8'h00) begin
            spi_tx_data_d = {1'b0, lowest_ch(rem_q), 12'h000};
            rem_d         = rem_q & ~(8'd1 << lowest_ch(rem_q));
            kind_d        = FR_CONV;
          end else begin
            // flush frame selects REFM and pulls out the last conversion
            spi_tx_data_d = 16'hC000;
            kind_d        = FR_FLUSH;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      kind_q      <= FR_CFR;
      rem_q       <= '0;
      gap_q       <= '0;
      prev_vld_q  <= 1'b0;
      prev_ch_q   <= '0;
      busy        <= 1'b0;
      sample_vld  <= 1'b0;
      sample_ch   <= '0;
      sample_data <= '0;
      sweep_done  <= 1'b0;
      spi_trig    <= 1'b0;
      spi_tx_data <= '0;
      err         <= 1'b0;
`ifdef TLV2548_SCAN_TIMEOUT_EN
      to_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      rem_q       <= rem_d;
      gap_q       <= gap_d;
      prev_vld_q  <= prev_vld_d;
      prev_ch_q   <= prev_ch_d;
      busy        <= busy_d;
      sample_vld  <= sample_vld_d;
      sample_ch   <= sample_ch_d;
      sample_data <= sample_data_d;
      sweep_done  <= sweep_done_d;
      spi_trig    <= spi_trig_d;
      spi_tx_data <= spi_tx_data_d;
      err         <= err_d;
`ifdef TLV2548_SCAN_TIMEOUT_EN
      to_q        <= to_d;
`endif
    end
  end

endmodule

// File: tb/tb_tlv2548_scan_ctrl.sv
`timescale 1ns/1ps
module tb_tlv2548_scan_ctrl;
  localparam int GAP = 10;
  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [11:0] cfg_word;
  logic [7:0]  ch_mask;
  logic        busy, sample_vld, sweep_done, spi_trig, err;
  logic [2:0]  sample_ch;
  logic [11:0] sample_data;
  logic [15:0] spi_tx_data;
  logic        spi_rdy, spi_done;
  logic [15:0] spi_rx_data;

  int vecs = 0;
  int miss = 0;
  int cyc  = 0;

  // SPI/ADC model controls and observation logs
  logic [11:0] code [8];
  bit          withhold = 1'b0;
  bit          spur_en  = 1'b0;
  int          rdy_hold = 0;
  logic [15:0] frames[$];
  int          trig_cyc[$], done_cyc[$], samp_cyc[$], sd_cyc[$], err_cyc[$];
  logic [14:0] samp_q[$];
  bit          sd_with_samp[$];

  typedef struct {
    logic [11:0] cfg;
    logic [7:0]  mask;
    int          nfr;
    int          nsmp;
    bit          inj;
    bit          atd;
    bit          spur;
    bit          rdyh;
  } vec_t;
  vec_t tbl[6];

  tlv2548_scan_ctrl #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_word(cfg_word), .ch_mask(ch_mask),
    .busy(busy), .sample_vld(sample_vld), .sample_ch(sample_ch), .sample_data(sample_data),
    .sweep_done(sweep_done), .spi_trig(spi_trig), .spi_tx_data(spi_tx_data),
    .spi_rdy(spi_rdy), .spi_done(spi_done), .spi_rx_data(spi_rx_data), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clr();
    frames.delete(); trig_cyc.delete(); done_cyc.delete(); samp_cyc.delete();
    sd_cyc.delete(); samp_q.delete(); sd_with_samp.delete(); err_cyc.delete();
  endtask

  // SPI core + ADC: each frame returns the code of the previous frame's channel
  initial begin : spi_model
    bit          xfer;
    int          lat, hold, spur;
    logic [15:0] cur, prev;
    xfer = 0; lat = 0; hold = 0; spur = 0; cur = '0; prev = 16'hFFFF;
    spi_rdy = 1'b0; spi_done = 1'b0; spi_rx_data = '0;
    forever begin
      @(negedge clk);
      spi_done = 1'b0;
      if (rst) begin
        xfer = 0; hold = 20; spur = 0; prev = 16'hFFFF;
      end else if (xfer) begin
        if (lat > 0) lat--;
        else if (!withhold) begin
          check("tx_stable", spi_tx_data, cur);
          spi_done    = 1'b1;
          spi_rx_data = prev[15] ? 16'($urandom) : {code[prev[14:12]], 4'h0};
          done_cyc.push_back(cyc);
          prev = cur; xfer = 0;
          hold = rdy_hold; rdy_hold = 0;
          if (spur_en) spur = 3;
        end
      end else begin
        if (spur > 0) begin
          spur--;
          if (spur == 0) begin
            spi_done    = 1'b1;
            spi_rx_data = 16'($urandom);
          end
        end
        if (spi_trig === 1'b1) begin
          check("trig_only_when_rdy", spi_rdy, 1'b1);
          frames.push_back(spi_tx_data);
          trig_cyc.push_back(cyc);
          cur = spi_tx_data; xfer = 1; lat = 2 + $urandom_range(0, 3);
        end
      end
      if (hold > 0) hold--;
      spi_rdy = !xfer && (hold == 0) && !rst;
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (sample_vld === 1'b1) begin
        samp_q.push_back({sample_ch, sample_data});
        samp_cyc.push_back(cyc);
      end
      if (sweep_done === 1'b1) begin
        sd_cyc.push_back(cyc);
        sd_with_samp.push_back(sample_vld);
      end
      if (err === 1'b1) err_cyc.push_back(cyc);
    end
  end

  task automatic run_sweep(input logic [11:0] cfg, input logic [7:0] mask, input int exp_fr,
                           input int exp_smp, input bit inj, input bit atd, input bit spur,
                           input bit rdyh, input string tag);
    logic [15:0] ef[$];
    logic [14:0] es[$];
    bit          seen;
    int          mingap;
    for (int c = 0; c < 8; c++) code[c] = 12'($urandom);
    // reference: frame list and tagged samples straight from the sweep rules
    ef.push_back({4'hA, cfg});
    for (int c = 0; c < 8; c++) if (mask[c]) ef.push_back({1'b0, 3'(c), 12'h000});
    if (mask != 8'h00) ef.push_back(16'hC000);
    for (int c = 0; c < 8; c++) if (mask[c]) es.push_back({3'(c), code[c]});
    clr();
    spur_en  = spur;
    rdy_hold = rdyh ? 50 : 0;
    @(negedge clk);
    cfg_word = cfg; ch_mask = mask; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cfg_word = 12'($urandom); ch_mask = 8'($urandom);
    check({tag, "_busy_on"}, busy, 1'b1);
    seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      start = inj && (i == 15 || i == 40);
      if (sweep_done === 1'b1) begin
        seen = 1;
        check({tag, "_busy_at_done"}, busy, 1'b1);
        if (atd) start = 1'b1;
      end
    end
    check({tag, "_sweep_done_seen"}, seen, 1'b1);
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_off"}, busy, 1'b0);
    repeat (30) @(negedge clk);
    check({tag, "_busy_idle"}, busy, 1'b0);
    check({tag, "_nframes"}, frames.size(), exp_fr);
    for (int k = 0; k < ef.size() && k < frames.size(); k++)
      check($sformatf("%s_frame%0d", tag, k), frames[k], ef[k]);
    check({tag, "_nsamples"}, samp_q.size(), exp_smp);
    for (int k = 0; k < es.size() && k < samp_q.size(); k++) begin
      check($sformatf("%s_sample%0d", tag, k), samp_q[k], es[k]);
      if (k + 2 < done_cyc.size())
        check($sformatf("%s_sample%0d_cyc", tag, k), samp_cyc[k], done_cyc[k + 2] + 1);
    end
    check({tag, "_nsweep_done"}, sd_cyc.size(), 1);
    if (sd_cyc.size() > 0 && done_cyc.size() > 0)
      check({tag, "_done_latency"}, sd_cyc[0], done_cyc[$] + 1);
    if (exp_smp > 0 && sd_with_samp.size() > 0)
      check({tag, "_done_with_sample"}, sd_with_samp[0], 1'b1);
    if (trig_cyc.size() > 1 && done_cyc.size() > 0) begin
      mingap = 1000000;
      for (int i = 1; i < trig_cyc.size() && i - 1 < done_cyc.size(); i++)
        if (trig_cyc[i] - done_cyc[i - 1] < mingap) mingap = trig_cyc[i] - done_cyc[i - 1];
      check({tag, "_gap_ok"}, mingap >= GAP, 1'b1);
      if (rdyh) check({tag, "_rdy_wait"}, (trig_cyc[1] - done_cyc[0]) >= 50, 1'b1);
    end
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit ok;
    rst = 1'b1; start = 1'b0; cfg_word = '0; ch_mask = '0;
    tbl[0] = '{12'h0F0, 8'h05, 4, 2, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{12'h123, 8'h00, 1, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{12'hFFF, 8'hFF, 10, 8, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{12'h5A5, 8'h24, 4, 2, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{12'h001, 8'h80, 3, 1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{12'hABC, 8'h01, 3, 1, 1'b0, 1'b0, 1'b0, 1'b0};
    repeat (3) @(negedge clk);
    check("reset_outputs", {busy, sample_vld, sweep_done, spi_trig, err, spi_tx_data,
                            sample_ch, sample_data}, '0);
    rst = 1'b0;
    repeat (25) @(negedge clk);

    for (int i = 0; i < 6; i++)
      run_sweep(tbl[i].cfg, tbl[i].mask, tbl[i].nfr, tbl[i].nsmp, tbl[i].inj, tbl[i].atd,
                tbl[i].spur, tbl[i].rdyh, $sformatf("v%0d", i));

    for (int r = 0; r < 6; r++) begin
      logic [7:0]  m;
      logic [11:0] c;
      m = 8'($urandom);
      c = 12'($urandom);
      run_sweep(c, m, (m == 8'h00) ? 1 : $countones(m) + 2, $countones(m),
                bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                bit'($urandom_range(0, 1)), 1'b0, $sformatf("r%0d", r));
    end

    // asynchronous reset in WAIT_DONE of the third frame
    clr();
    for (int c = 0; c < 8; c++) code[c] = 12'($urandom);
    @(negedge clk);
    cfg_word = 12'h3C3; ch_mask = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ok = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (trig_cyc.size() == 3 && done_cyc.size() == 2) ok = 1;
    end
    check("rst_reach_frame3", ok, 1'b1);
    #2 rst = 1'b1;
    #1 check("rst_outputs", {busy, sample_vld, sweep_done, spi_trig, err, spi_tx_data,
                             sample_ch, sample_data}, '0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    clr();
    repeat (10) @(negedge clk);
    check("rst_no_samples", samp_q.size(), 0);
    check("rst_no_sweep_done", sd_cyc.size(), 0);
    check("rst_no_trig", trig_cyc.size(), 0);
    run_sweep(12'h777, 8'hFF, 10, 8, 1'b0, 1'b0, 1'b0, 1'b0, "post_rst");

`ifdef TLV2548_SCAN_TIMEOUT_EN
    clr();
    withhold = 1'b1;
    @(negedge clk);
    cfg_word = 12'h111; ch_mask = 8'h03; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (err_cyc.size() > 0) ok = 1;
    end
    check("tmo_err_seen", ok, 1'b1);
    if (ok && trig_cyc.size() > 0) check("tmo_err_cyc", err_cyc[0] - trig_cyc[0], TMO);
    @(negedge clk);
    check("tmo_busy_off", busy, 1'b0);
    repeat (20) @(negedge clk);
    check("tmo_no_sweep_done", sd_cyc.size(), 0);
    check("tmo_no_samples", samp_q.size(), 0);
    check("tmo_single_err", err_cyc.size(), 1);
    withhold = 1'b0;
    repeat (20) @(negedge clk);
`else
    check("err_never", err_cyc.size(), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
